// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
package mips_mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int MAX_MEM_RUN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and RAM-side signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  // slave: the arbiter itself; master: the pipeline stages plus the RAM model
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_ack, ram_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_ack, ram_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between IF fetches and MEM loads/stores.
// state    | meaning
// IDLE     | no RAM access in flight; arbitrate pending requests
// BUSY_IF  | fetch in flight, waiting for ram_ack
// BUSY_MEM | load/store in flight, waiting for ram_ack
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_MEM_RUN = MAX_MEM_RUN_DEF
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_MEM_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MEM_RUN);

  arb_state_t        state, state_nx;
  logic [CNT_W-1:0]  starve_cnt, starve_nx;
  logic              we_q, we_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic              if_valid_q, if_valid_nx;
  logic              mem_valid_q, mem_valid_nx;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_nx;
  logic              mem_op;
  logic              grant_mem;

  assign mem_op    = bus.mem_rd | bus.mem_wr;
  // MEM wins unless IF is waiting and MEM has used up its run allowance
  assign grant_mem = mem_op & (~bus.if_req | (starve_cnt < CNT_MAX));

  always_comb begin
    state_nx     = state;
    starve_nx    = starve_cnt;
    we_nx        = we_q;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    if_valid_nx  = 1'b0;
    mem_valid_nx = 1'b0;
    if_rdata_nx  = if_rdata_q;
    mem_rdata_nx = mem_rdata_q;
    case (state)
      IDLE: begin
        if (!bus.if_req) starve_nx = '0;
        if (grant_mem) begin
          state_nx = BUSY_MEM;
          addr_nx  = bus.mem_addr;
          wdata_nx = bus.mem_wdata;
          we_nx    = bus.mem_wr;
          if (bus.if_req && (starve_cnt < CNT_MAX)) starve_nx = starve_cnt + CNT_W'(1);
        end else if (bus.if_req) begin
          state_nx  = BUSY_IF;
          addr_nx   = bus.if_addr;
          we_nx     = 1'b0;
          starve_nx = '0;
        end
      end
      BUSY_IF: begin
        if (bus.ram_ack) begin
          state_nx    = IDLE;
          if_valid_nx = 1'b1;
          if_rdata_nx = bus.ram_rdata;
        end
      end
      BUSY_MEM: begin
        if (bus.ram_ack) begin
          state_nx     = IDLE;
          mem_valid_nx = 1'b1;
          if (!we_q) mem_rdata_nx = bus.ram_rdata;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state       <= state_nx;
      starve_cnt  <= starve_nx;
      we_q        <= we_nx;
      addr_q      <= addr_nx;
      wdata_q     <= wdata_nx;
      if_valid_q  <= if_valid_nx;
      mem_valid_q <= mem_valid_nx;
      if_rdata_q  <= if_rdata_nx;
      mem_rdata_q <= mem_rdata_nx;
    end
  end

  assign bus.ram_req   = (state != IDLE);
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  // stalls depend only on requests and the valid registers, never on ram_ack
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.mem_stall = mem_op & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: reset-time stall table, directed corner sequences, randomized traffic vs. a transaction model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_RUN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_ram(input string name, input logic req, input logic we, input logic [31:0] addr);
    chk({name, ".ram_req"}, 32'(bus.ram_req), 32'(req));
    chk({name, ".ram_we"}, 32'(bus.ram_we), 32'(we));
    chk({name, ".ram_addr"}, bus.ram_addr, addr);
  endtask

  typedef struct {
    logic ir, mr, mw;
    logic exp_is, exp_ms;
  } vec_t;

  // transaction-level reference state for the random phase
  logic [31:0] model [0:7];
  logic [31:0] last_load;
  int          run, owner, lat;
  logic        pi_prev, pm_prev, req_prev, ack_was, exp_ifv, exp_memv, exp_mem;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  initial begin
    vec_t vecs [8];
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.if_req = 0; bus.if_addr = 0; bus.mem_rd = 0; bus.mem_wr = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0; bus.ram_ack = 0; bus.ram_rdata = 0;

    // stalls while held in reset: valid registers are 0, so stall = request
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      bus.if_req = vecs[i].ir; bus.mem_rd = vecs[i].mr; bus.mem_wr = vecs[i].mw;
      #1;
      chk($sformatf("tbl%0d.if_stall", i), 32'(bus.if_stall), 32'(vecs[i].exp_is));
      chk($sformatf("tbl%0d.mem_stall", i), 32'(bus.mem_stall), 32'(vecs[i].exp_ms));
      chk($sformatf("tbl%0d.ram_req", i), 32'(bus.ram_req), 32'd0);
      tick();
    end
    bus.if_req = 0; bus.mem_rd = 0; bus.mem_wr = 0;
    tick(); rst = 0; tick();

    // 1: reset in the middle of BUSY_MEM
    bus.mem_wr = 1; bus.mem_addr = 32'h44; bus.mem_wdata = 32'hA5A5A5A5;
    tick();
    chk("rst.pre_req", 32'(bus.ram_req), 32'd1);
    rst = 1;
    tick();
    chk_ram("rst", 1'b0, 1'b0, 32'h0);
    chk("rst.ram_wdata", bus.ram_wdata, 32'h0);
    chk("rst.if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst.mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst.if_rdata", bus.if_rdata, 32'h0);
    chk("rst.mem_rdata", bus.mem_rdata, 32'h0);
    tick();
    bus.mem_wr = 0; rst = 0;
    tick();
    chk("rst.after_req", 32'(bus.ram_req), 32'd0);

    // 2: lone load, ack in the third BUSY cycle
    bus.mem_rd = 1; bus.mem_addr = 32'h40;
    tick();
    chk_ram("load", 1'b1, 1'b0, 32'h40);
    chk("load.stall", 32'(bus.mem_stall), 32'd1);
    tick();
    chk("load.wait_valid", 32'(bus.mem_valid), 32'd0);
    tick();
    chk("load.wait_req", 32'(bus.ram_req), 32'd1);
    bus.ram_ack = 1; bus.ram_rdata = 32'hDEADBEEF;
    tick();
    bus.ram_ack = 0;
    chk("load.valid", 32'(bus.mem_valid), 32'd1);
    chk("load.rdata", bus.mem_rdata, 32'hDEADBEEF);
    chk("load.stall_low", 32'(bus.mem_stall), 32'd0);
    chk("load.req_low", 32'(bus.ram_req), 32'd0);
    bus.mem_rd = 0;
    tick();
    chk("load.pulse_end", 32'(bus.mem_valid), 32'd0);

    // 3: store leaves mem_rdata untouched
    bus.mem_wr = 1; bus.mem_addr = 32'h80; bus.mem_wdata = 32'h12345678;
    tick();
    chk_ram("store", 1'b1, 1'b1, 32'h80);
    chk("store.wdata", bus.ram_wdata, 32'h12345678);
    bus.ram_ack = 1; bus.ram_rdata = 32'h0BADF00D;
    tick();
    bus.ram_ack = 0;
    chk("store.valid", 32'(bus.mem_valid), 32'd1);
    chk("store.rdata_kept", bus.mem_rdata, 32'hDEADBEEF);
    bus.mem_wr = 0;
    tick();

    // 4: simultaneous IF and MEM request
    bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_rd = 1; bus.mem_addr = 32'h44;
    tick();
    chk_ram("conf.mem", 1'b1, 1'b0, 32'h44);
    chk("conf.if_stall0", 32'(bus.if_stall), 32'd1);
    bus.ram_ack = 1; bus.ram_rdata = 32'h11111111;
    tick();
    bus.ram_ack = 0;
    chk("conf.mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("conf.if_stall1", 32'(bus.if_stall), 32'd1);
    bus.mem_rd = 0;
    tick();
    chk_ram("conf.if", 1'b1, 1'b0, 32'h100);
    chk("conf.if_stall2", 32'(bus.if_stall), 32'd1);
    bus.ram_ack = 1; bus.ram_rdata = 32'h22222222;
    tick();
    bus.ram_ack = 0;
    chk("conf.if_valid", 32'(bus.if_valid), 32'd1);
    chk("conf.if_rdata", bus.if_rdata, 32'h22222222);
    chk("conf.if_stall3", 32'(bus.if_stall), 32'd0);
    bus.if_req = 0;
    tick();

    // 5: starvation limit -- four MEM grants then a forced IF grant
    bus.if_req = 1; bus.if_addr = 32'h200; bus.mem_rd = 1; bus.mem_addr = 32'h300;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk_ram($sformatf("starve%0d", g), 1'b1, 1'b0, (g < 4) ? 32'h300 : 32'h200);
      bus.ram_ack = 1; bus.ram_rdata = 32'h5000 + 32'(g);
      tick();
      bus.ram_ack = 0;
      chk($sformatf("starve%0d.valid", g), (g < 4) ? 32'(bus.mem_valid) : 32'(bus.if_valid), 32'd1);
    end
    chk("starve.if_rdata", bus.if_rdata, 32'h5004);
    bus.if_req = 0; bus.mem_rd = 0;
    tick();

    // 6: spurious ack in IDLE, then zero-wait load
    bus.ram_ack = 1; bus.ram_rdata = 32'hFFFFFFFF;
    tick();
    bus.ram_ack = 0;
    chk("spur.if_valid", 32'(bus.if_valid), 32'd0);
    chk("spur.mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("spur.ram_req", 32'(bus.ram_req), 32'd0);
    bus.mem_rd = 1; bus.mem_addr = 32'h48;
    tick();
    chk("zw.req", 32'(bus.ram_req), 32'd1);
    bus.ram_ack = 1; bus.ram_rdata = 32'hCAFEF00D;
    tick();
    bus.ram_ack = 0;
    chk("zw.valid", 32'(bus.mem_valid), 32'd1);
    chk("zw.rdata", bus.mem_rdata, 32'hCAFEF00D);
    bus.mem_rd = 0;
    tick();

    // randomized traffic against a transaction model
    rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < 8; i++) model[i] = $urandom;
    last_load = 0; run = 0; owner = 0; lat = 0;
    pi_prev = 0; pm_prev = 0; req_prev = 0;
    h_addr = 0; h_wdata = 0; h_we = 0;
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ack_was  = bus.ram_ack && req_prev;
      exp_ifv  = ack_was && (owner == 1);
      exp_memv = ack_was && (owner == 2);
      chk("rnd.if_valid", 32'(bus.if_valid), 32'(exp_ifv));
      chk("rnd.mem_valid", 32'(bus.mem_valid), 32'(exp_memv));
      if (exp_ifv) chk("rnd.if_rdata", bus.if_rdata, model[bus.if_addr[4:2]]);
      if (exp_memv) begin
        if (!bus.mem_wr) last_load = model[bus.mem_addr[4:2]];
        chk("rnd.mem_rdata", bus.mem_rdata, last_load);
      end
      if (ack_was) owner = 0;
      chk("rnd.if_stall", 32'(bus.if_stall), 32'(bus.if_req && !exp_ifv));
      chk("rnd.mem_stall", 32'(bus.mem_stall), 32'((bus.mem_rd || bus.mem_wr) && !exp_memv));

      if (!req_prev) begin
        if (!pi_prev) run = 0;
        if (pi_prev || pm_prev) begin
          exp_mem = pm_prev && (!pi_prev || run < 4);
          h_we    = exp_mem ? bus.mem_wr : 1'b0;
          h_addr  = exp_mem ? bus.mem_addr : bus.if_addr;
          h_wdata = bus.mem_wdata;
          chk_ram("rnd.grant", 1'b1, h_we, h_addr);
          if (exp_mem && h_we) chk("rnd.grant.wdata", bus.ram_wdata, h_wdata);
          if (exp_mem) run = pi_prev ? ((run < 4) ? run + 1 : 4) : 0;
          else run = 0;
          owner = exp_mem ? 2 : 1;
          lat   = int'($urandom_range(0, 3));
        end else begin
          chk("rnd.idle_req", 32'(bus.ram_req), 32'd0);
        end
      end else if (bus.ram_req) begin
        chk_ram("rnd.hold", 1'b1, h_we, h_addr);
        if (h_we) chk("rnd.hold.wdata", bus.ram_wdata, h_wdata);
      end

      // RAM model
      if (bus.ram_ack) bus.ram_ack = 0;
      else if (bus.ram_req && owner != 0) begin
        if (lat == 0) begin
          bus.ram_ack = 1;
          if (h_we) begin
            bus.ram_rdata = $urandom;
            model[h_addr[4:2]] = h_wdata;
          end else bus.ram_rdata = model[h_addr[4:2]];
        end else lat--;
      end else if (!bus.ram_req && ($urandom_range(0, 7) == 0)) begin
        bus.ram_ack = 1; bus.ram_rdata = $urandom;
      end

      // stage agents: drop on completion, otherwise occasionally issue
      if (exp_ifv) bus.if_req = 0;
      else if (!bus.if_req && ($urandom_range(0, 2) == 0)) begin
        bus.if_req = 1; bus.if_addr = {27'd0, 3'($urandom), 2'b00};
      end
      if (exp_memv) begin
        bus.mem_rd = 0; bus.mem_wr = 0;
      end else if (!(bus.mem_rd || bus.mem_wr) && ($urandom_range(0, 1) == 0)) begin
        case ($urandom_range(0, 2))
          0: begin bus.mem_rd = 1; bus.mem_wr = 0; end
          1: begin bus.mem_rd = 0; bus.mem_wr = 1; end
          default: begin bus.mem_rd = 1; bus.mem_wr = 1; end
        endcase
        bus.mem_addr = {27'd0, 3'($urandom), 2'b00};
        bus.mem_wdata = $urandom;
      end

      pi_prev  = bus.if_req;
      pm_prev  = bus.mem_rd || bus.mem_wr;
      req_prev = bus.ram_req;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
